// File: rtl/report_bram_arbiter.sv
// report_bram_arbiter: shares one single-port report BRAM between the
// computation-side record writer and the UART-side record reader.
// Writes win by default. A write burst is capped while a read waits so the
// reader cannot starve. Read data returns through a latency-matched valid
// pipeline, and a saturating write-level counter bounds UART readback.
module report_bram_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 24,
  parameter int RD_LATENCY   = 1,
  parameter int MAX_WR_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   wr_count,
  output logic [1:0]        phase
);

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_WRITE = 2'd1,
    PH_READ  = 2'd2
  } phase_t;

  localparam logic [3:0]    LP_MAX_BURST = 4'(MAX_WR_BURST);
  localparam logic [ADDR_W:0] LP_WR_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [3:0]            r_burst_cnt;
  logic [RD_LATENCY-1:0] r_vld_sr;
  logic                  r_rd_valid;
  logic [DATA_W-1:0]     r_rd_data;
  logic [ADDR_W:0]       r_wr_count;
  phase_t                r_phase;
  phase_t                w_phase_nxt;
  logic                  w_wr_gnt;
  logic                  w_rd_gnt;
  logic                  w_vld_tail;

  // Grants are masked while reset is held so the BRAM sees no access then.
  // A waiting read only takes the port once the write burst reaches its cap.
  assign w_wr_gnt   = rst_n & wr_req & (~rd_req | (r_burst_cnt < LP_MAX_BURST));
  assign w_rd_gnt   = rst_n & rd_req & ~w_wr_gnt;
  assign w_vld_tail = r_vld_sr[RD_LATENCY-1];

  assign wr_gnt    = w_wr_gnt;
  assign rd_gnt    = w_rd_gnt;
  assign mem_en    = w_wr_gnt | w_rd_gnt;
  assign mem_we    = w_wr_gnt;
  assign mem_addr  = w_wr_gnt ? wr_addr : (w_rd_gnt ? rd_addr : '0);
  assign mem_wdata = w_wr_gnt ? wr_data : '0;

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign wr_count = r_wr_count;
  assign phase    = r_phase;

  // Count writes that overtook a waiting read; any read grant or idle reader restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else if (clear) begin
      r_burst_cnt <= '0;
    end else if (w_rd_gnt || !rd_req) begin
      r_burst_cnt <= '0;
    end else if (w_wr_gnt) begin
      r_burst_cnt <= r_burst_cnt + 4'd1;
    end
  end

  // Track each read grant through the BRAM latency; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= w_rd_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
      end
    end
  end

  // Capture the BRAM output when its read arrives and flag it one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_vld_tail;
      if (w_vld_tail) begin
        r_rd_data <= mem_rdata;
      end
    end
  end

  // Saturating count of accepted writes, used by the reader as a fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_count <= '0;
    end else if (clear) begin
      r_wr_count <= '0;
    end else if (w_wr_gnt && (r_wr_count != LP_WR_FULL)) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end

  // Decide which kind of grant this cycle reports as the next phase.
  always_comb begin
    w_phase_nxt = PH_IDLE;
    if (w_wr_gnt) begin
      w_phase_nxt = PH_WRITE;
    end else if (w_rd_gnt) begin
      w_phase_nxt = PH_READ;
    end
  end

  // Register the phase so it reports the previous cycle's grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_IDLE;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

endmodule

// File: tb/tb_report_bram_arbiter.sv
// tb_report_bram_arbiter: drives writer/reader handshakes against a BRAM
// model, predicts grants, counters and read data with an independent
// reference model, and compares returned records through a scoreboard queue.
module tb_report_bram_arbiter;

  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 24;
  localparam int RD_LATENCY   = 1;
  localparam int MAX_WR_BURST = 4;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W:0]   wr_count;
  logic [1:0]        phase;

  logic [DATA_W-1:0] bram   [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] sbQ [$];

  int nChecks = 0;
  int nErrors = 0;

  int       mBurst;
  int       mWrCount;
  int       mPhase;
  bit       mV1;
  bit       mV2;
  bit       expWr;
  bit       expRd;
  logic [ADDR_W-1:0] expAddr;

  report_bram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RD_LATENCY(RD_LATENCY), .MAX_WR_BURST(MAX_WR_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wr_count(wr_count), .phase(phase)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  // Count one comparison and report it if it disagrees
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Realign the driver to just after the active edge
  task automatic syncStep();
    @(posedge clk);
    #1;
  endtask

  // Present one write, wait (bounded) for its grant, then step past the edge
  task automatic wrBeat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int t;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!wr_gnt && t < 64);
    checkOutput("wr_gnt_seen", 32'(wr_gnt), 32'd1);
    syncStep();
  endtask

  // Present one read, wait (bounded) for its grant, then step past the edge
  task automatic rdBeat(input logic [ADDR_W-1:0] a);
    int t;
    rd_req  = 1'b1;
    rd_addr = a;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rd_gnt && t < 64);
    checkOutput("rd_gnt_seen", 32'(rd_gnt), 32'd1);
    syncStep();
  endtask

  // Reference model and scoreboard, evaluated mid-cycle with inputs stable
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_wr_gnt",   32'(wr_gnt),   32'd0);
      checkOutput("rst_rd_gnt",   32'(rd_gnt),   32'd0);
      checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("rst_rd_data",  32'(rd_data),  32'd0);
      checkOutput("rst_wr_count", 32'(wr_count), 32'd0);
      checkOutput("rst_phase",    32'(phase),    32'd0);
      checkOutput("rst_mem_en",   32'(mem_en),   32'd0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
      mBurst = 0; mWrCount = 0; mPhase = 0; mV1 = 0; mV2 = 0;
      sbQ.delete();
    end else begin
      expWr = wr_req && (!rd_req || mBurst < MAX_WR_BURST);
      expRd = rd_req && !expWr;
      expAddr = expWr ? wr_addr : (expRd ? rd_addr : '0);
      checkOutput("wr_gnt",    32'(wr_gnt),    32'(expWr));
      checkOutput("rd_gnt",    32'(rd_gnt),    32'(expRd));
      checkOutput("mem_en",    32'(mem_en),    32'(expWr || expRd));
      checkOutput("mem_we",    32'(mem_we),    32'(expWr));
      checkOutput("mem_addr",  32'(mem_addr),  32'(expAddr));
      checkOutput("mem_wdata", 32'(mem_wdata), expWr ? 32'(wr_data) : 32'd0);
      checkOutput("phase",     32'(phase),     32'(mPhase));
      checkOutput("wr_count",  32'(wr_count),  32'(mWrCount));
      checkOutput("rd_valid",  32'(rd_valid),  32'(mV2));
      if (rd_valid) begin
        if (sbQ.size() == 0) checkOutput("sb_underflow", 32'(sbQ.size()), 32'd1);
        else checkOutput("rd_data", 32'(rd_data), 32'(sbQ.pop_front()));
      end
      if (expRd) sbQ.push_back(shadow[rd_addr]);
      if (expWr) shadow[wr_addr] = wr_data;
      mV2 = mV1;
      mV1 = expRd;
      mPhase = expWr ? 1 : (expRd ? 2 : 0);
      if (clear) mWrCount = 0;
      else if (expWr && mWrCount < (1 << ADDR_W)) mWrCount++;
      if (clear || expRd || !rd_req) mBurst = 0;
      else if (expWr) mBurst++;
    end
  end

  // Directed sequences from the test plan
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      bram[i]   = '0;
      shadow[i] = '0;
    end
    bram[5]   = 24'h0A0B0C;
    shadow[5] = 24'h0A0B0C;
    rst_n = 1'b0; clear = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    syncStep();

    $display("[TB] single read of preloaded record");
    rd_req = 1'b1; rd_addr = 8'h05;
    @(negedge clk);
    checkOutput("t1_rd_gnt", 32'(rd_gnt), 32'd1);
    syncStep();
    rd_req = 1'b0;
    @(negedge clk);
    checkOutput("t1_early_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    checkOutput("t1_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("t1_rd_data",  32'(rd_data),  32'h0A0B0C);
    syncStep();

    $display("[TB] ten writes, no reads");
    for (int i = 0; i < 10; i++) wrBeat(8'(i), 24'h100000 + 24'(i * 24'h010101));
    wr_req = 1'b0;
    checkOutput("t2_wr_count", 32'(wr_count), 32'd10);
    checkOutput("t2_phase",    32'(phase),    32'd1);
    syncStep();

    $display("[TB] contending writer and reader");
    fork
      begin
        for (int i = 0; i < 16; i++) wrBeat(8'(8'h60 + i), 24'($urandom()));
        wr_req = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) rdBeat(8'(i));
        rd_req = 1'b0;
      end
    join
    repeat (3) syncStep();

    $display("[TB] read after write");
    wrBeat(8'h20, 24'h112233);
    wr_req = 1'b0;
    rdBeat(8'h20);
    rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("t4_rd_data",  32'(rd_data),  32'h112233);
    syncStep();

    $display("[TB] write counter saturation and clear");
    for (int i = 0; i < 300; i++) wrBeat(8'(i), 24'($urandom()));
    wr_req = 1'b0;
    checkOutput("t5_wr_sat", 32'(wr_count), 32'd256);
    clear = 1'b1;
    wrBeat(8'h50, 24'hABCDEF);
    clear = 1'b0; wr_req = 1'b0;
    checkOutput("t5_clr_wr", 32'(wr_count), 32'd0);
    syncStep();

    $display("[TB] reset with reads in flight");
    rdBeat(8'h05);
    rdBeat(8'h20);
    rdBeat(8'h03);
    rd_req = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    syncStep();
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("t6_no_valid", 32'(rd_valid), 32'd0);
    end
    checkOutput("t6_rd_data", 32'(rd_data), 32'd0);
    syncStep();

    repeat (4) syncStep();
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/report_bram_arbiter.md
Name: report_bram_arbiter

Overview:
Shares one single-port report BRAM between two requesters. The computation-side writer streams count/word records in. The UART-side reader fetches records for transmission. The block replaces the static enable-based address mux with per-cycle arbitration, a starvation guard, a read-data pipeline and a write-level counter that bounds UART readback.

Parameters:
ADDR_W, 8, BRAM address width.
DATA_W, 24, record width ({word_report, count_b2, count_b1}, 8 bits each).
RD_LATENCY, 1, BRAM read latency in cycles from mem_en to mem_rdata valid (legal 1..4).
MAX_WR_BURST, 4, max consecutive write grants while a read is pending (legal 1..15).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  synchronous clear of wr_count and burst_cnt.
wr_req  in  1  writer request; held until wr_gnt.
wr_addr  in  ADDR_W  write address; stable while wr_req.
wr_data  in  DATA_W  write record; stable while wr_req.
wr_gnt  out  1  write performed this cycle.
rd_req  in  1  reader request; held until rd_gnt.
rd_addr  in  ADDR_W  read address; stable while rd_req.
rd_gnt  out  1  read issued this cycle.
rd_valid  out  1  one-cycle pulse: rd_data is valid.
rd_data  out  DATA_W  returned record; holds last value.
mem_en  out  1  BRAM enable.
mem_we  out  1  BRAM write enable.
mem_addr  out  ADDR_W  BRAM address.
mem_wdata  out  DATA_W  BRAM write data.
mem_rdata  in  DATA_W  BRAM read data.
wr_count  out  ADDR_W+1  accepted writes since reset/clear; saturates at 2^ADDR_W.
phase  out  2  last grant: 0 idle, 1 write, 2 read.

Behaviour:
- Reset (rst_n low, async): wr_gnt=0, rd_gnt=0, rd_valid=0, rd_data=0, wr_count=0, phase=0, burst_cnt=0. Read pipeline is flushed. mem_* follow the grants, so all are 0.
- Grants are combinational from the requests and registered burst_cnt. At most one grant per cycle.
  - Only wr_req: wr_gnt=1.
  - Only rd_req: rd_gnt=1.
  - Both requests, burst_cnt<MAX_WR_BURST: wr_gnt=1.
  - Both requests, burst_cnt==MAX_WR_BURST: rd_gnt=1.
- burst_cnt (4-bit register):
  - +1 on wr_gnt while rd_req=1.
  - Cleared on rd_gnt, or on any cycle with rd_req=0.
  - Cleared by clear.
  - If clear coincides with an increment, clear wins.
- Memory drive:
  - mem_en = wr_gnt|rd_gnt; mem_we = wr_gnt.
  - mem_addr = wr_addr on a write grant, rd_addr on a read grant, else 0.
  - mem_wdata = wr_data on a write grant, else 0.
- Read pipeline:
  - RD_LATENCY-deep valid shift register is loaded with rd_gnt.
  - When the tail is 1, mem_rdata is captured into rd_data.
  - rd_valid pulses the cycle after capture, so total latency is RD_LATENCY+1 cycles after the grant cycle.
  - Back-to-back reads return one rd_valid per cycle, in order.
  - Writes granted during the pipeline do not disturb in-flight reads.
- Read-after-write to the same address on a later cycle returns the new data. No same-cycle conflict is possible.
- wr_count:
  - +1 per wr_gnt, saturating at 2^ADDR_W.
  - clear sets it to 0. clear coincident with wr_gnt gives 0.
  - Not affected by reads.
- phase is registered:
  - 1 after wr_gnt, 2 after rd_gnt.
  - 0 after a cycle with no grant.
- A request dropped before its grant is a protocol violation. No grant is guaranteed for it, and no state corruption results.
- rst_n asserted mid-operation: in-flight reads produce no rd_valid after reset is released.

Test Plan:
- Reset, then rd_req at address 0x05 with BRAM preloaded 0x0A0B0C, RD_LATENCY=1 -> rd_gnt same cycle; rd_valid pulses 2 cycles later with rd_data=0x0A0B0C.
- 10 consecutive writes with no reads (addresses 0..9) -> wr_gnt every cycle; wr_count=10; phase=1; mem_we=1 on each cycle.
- Continuous wr_req and rd_req, MAX_WR_BURST=4 -> grant pattern W,W,W,W,R repeating; burst_cnt peaks at 4; each read returns data reflecting prior writes.
- Write 0x112233 to address 0x20, then read 0x20 on the next cycle -> rd_data=0x112233 after RD_LATENCY+1 cycles.
- ADDR_W=8: 300 writes -> wr_count saturates at 256. clear coincident with a wr_gnt -> wr_count=0 the next cycle.
- Three back-to-back reads issued, rst_n pulsed low one cycle later -> no rd_valid pulses after release; all outputs are 0 after reset.
